// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction-fetch sequencer: tick one-hots,
// FSM encoding, instruction width and default address width.
package instr_sequencer_pkg;

   localparam int unsigned AW_DEFAULT = 5;
   localparam int unsigned IW         = 9;

   typedef logic [IW-1:0] instr_t;

   localparam logic [3:0] T1 = 4'b0001;
   localparam logic [3:0] T2 = 4'b0010;
   localparam logic [3:0] T3 = 4'b0100;
   localparam logic [3:0] T4 = 4'b1000;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_STEP = 2'b10;
   localparam logic [1:0] S_HALT = 2'b11;

   function automatic logic is_active(input logic [1:0] s);
      return (s == S_RUN) || (s == S_STEP);
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control, program-load and processor-facing signals of the sequencer.
// master drives the controls and tick; slave is the sequencer itself.
interface instr_sequencer_if
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT
);
   logic [3:0]    tick;
   logic          run;
   logic          step;
   logic          restart;
   logic [AW-1:0] end_addr;
   logic          load_we;
   logic [AW-1:0] load_addr;
   instr_t        load_data;

   instr_t        din;
   logic [AW-1:0] pc;
   logic          proc_enable;
   logic [1:0]    state;
   logic          halted;
   logic [15:0]   retired;

   modport master (
      output tick, run, step, restart, end_addr, load_we, load_addr, load_data,
      input  din, pc, proc_enable, state, halted, retired
   );

   modport slave (
      input  tick, run, step, restart, end_addr, load_we, load_addr, load_data,
      output din, pc, proc_enable, state, halted, retired
   );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: 2^AW x 9 register array, async clear, one synchronous
// write port and one combinational read port.
module prog_mem
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  instr_t        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output instr_t        rdata_o
);
   localparam int unsigned DEPTH = 1 << AW;

   instr_t mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-fetch sequencer: program counter, run/step/pause/halt FSM and
// retired-instruction counter gating the processor's tick FSM.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT
) (
   input logic               clk,
   input logic               rst,
   instr_sequencer_if.slave  bus
);
   logic [1:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          en_q, en_d;
   logic [15:0]   retired_q, retired_d;
   logic          step_q;

   logic          retire;
   logic          step_edge;
   logic          at_end;
   logic          mem_we;

   assign retire    = en_q && (bus.tick == T4);
   assign step_edge = bus.step && !step_q;
   assign at_end    = (pc_q == bus.end_addr);
   assign mem_we    = bus.load_we && ((state_q == S_IDLE) || (state_q == S_HALT));

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;

      case (state_q)
         S_IDLE: begin
            if (bus.run) begin
               state_d = S_RUN;
            end else if (step_edge) begin
               state_d = S_STEP;
            end else if (bus.restart) begin
               pc_d = '0;
            end
         end
         S_RUN: begin
            if (retire) begin
               if (at_end) begin
                  state_d = S_HALT;
               end else if (!bus.run) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_STEP: begin
            if (retire) begin
               state_d = at_end ? S_HALT : S_IDLE;
            end
         end
         S_HALT: begin
            if (bus.restart) begin
               pc_d    = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (retire) begin
         pc_d      = pc_q + 1'b1;
         retired_d = retired_q + 16'd1;
      end

      // Enable rises one cycle after entering RUN/STEP, but drops on the retire edge itself.
      en_d = is_active(state_q) && is_active(state_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         en_q      <= 1'b0;
         retired_q <= '0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         en_q      <= en_d;
         retired_q <= retired_d;
         step_q    <= bus.step;
      end
   end

   prog_mem #(.AW(AW)) u_prog_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (mem_we),
      .waddr_i (bus.load_addr),
      .wdata_i (bus.load_data),
      .raddr_i (pc_q),
      .rdata_o (bus.din)
   );

   assign bus.pc          = pc_q;
   assign bus.state       = state_q;
   assign bus.proc_enable = en_q;
   assign bus.halted      = (state_q == S_HALT);
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios then random control traffic,
// every cycle compared against an instruction-level reference model.
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   localparam int unsigned AW    = 5;
   localparam int          DEPTH = 32;
   localparam int          M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   instr_sequencer_if #(.AW(AW)) sif ();

   instr_sequencer #(.AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: mode, pc, retired count, enable, step history, tick slot, memory image
   int m_mode, m_pc, m_retired, m_tickn;
   bit m_en, m_stepq;
   int m_mem [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_mode = M_IDLE; m_pc = 0; m_retired = 0; m_tickn = 0;
      m_en = 0; m_stepq = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
   endtask

   function automatic bit executing(input int mode);
      return (mode == M_RUN) || (mode == M_STEP);
   endfunction

   task automatic model_edge();
      bit retire, sedge, nen;
      int nmode, npc;
      if (rst) begin
         m_reset();
         return;
      end
      retire = m_en && (m_tickn == 3);
      sedge  = sif.step && !m_stepq;
      nmode  = m_mode;
      npc    = m_pc;
      if (m_mode == M_IDLE) begin
         if (sif.run) nmode = M_RUN;
         else if (sedge) nmode = M_STEP;
         else if (sif.restart) npc = 0;
      end else if (m_mode == M_HALT) begin
         if (sif.restart) begin npc = 0; nmode = M_IDLE; end
      end else if (retire) begin
         if (m_pc == int'(sif.end_addr)) nmode = M_HALT;
         else if (m_mode == M_STEP || !sif.run) nmode = M_IDLE;
      end
      if (retire) begin
         npc = (m_pc + 1) % DEPTH;
         m_retired = (m_retired + 1) % 65536;
      end
      if (sif.load_we && (m_mode == M_IDLE || m_mode == M_HALT))
         m_mem[sif.load_addr] = int'(sif.load_data);
      nen = executing(m_mode) && executing(nmode);
      if (m_en) m_tickn = (m_tickn + 1) % 4;
      m_en = nen; m_mode = nmode; m_pc = npc; m_stepq = sif.step;
   endtask

   task automatic compare_all(input string pfx);
      check({pfx, "_state"},   sif.state,       m_mode);
      check({pfx, "_pc"},      sif.pc,          m_pc);
      check({pfx, "_din"},     sif.din,         m_mem[m_pc]);
      check({pfx, "_en"},      sif.proc_enable, m_en);
      check({pfx, "_halted"},  sif.halted,      m_mode == M_HALT);
      check({pfx, "_retired"}, sif.retired,     m_retired);
   endtask

   // One clock: model and DUT advance together, tick FSM follows, compare at negedge
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1 sif.tick = 4'b0001 << m_tickn;
      @(negedge clk);
      compare_all("cyc");
   endtask

   task automatic wait_state(input logic [1:0] s, input int limit, input string tag);
      int n = 0;
      while (sif.state !== s && n < limit) begin cyc(); n++; end
      check(tag, sif.state, s);
   endtask

   task automatic wait_pc(input int p, input int limit, input string tag);
      int n = 0;
      while (sif.pc !== p[AW-1:0] && n < limit) begin cyc(); n++; end
      check(tag, sif.pc, p);
   endtask

   task automatic load(input int addr, input int data);
      sif.load_we = 1'b1; sif.load_addr = addr[AW-1:0]; sif.load_data = data[8:0];
      cyc();
      sif.load_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, en_cnt;
      sif.tick = T1; sif.run = 0; sif.step = 0; sif.restart = 0;
      sif.end_addr = '0; sif.load_we = 0; sif.load_addr = '0; sif.load_data = '0;
      m_reset();

      // Reset for 3 cycles
      #1 rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      check("rst_din", sif.din, 0);
      check("rst_pc", sif.pc, 0);
      check("rst_en", sif.proc_enable, 0);
      check("rst_state", sif.state, 2'b00);
      check("rst_retired", sif.retired, 0);
      check("rst_halted", sif.halted, 0);

      // Load three words and run to end_addr=2
      load(0, 9'h008); load(1, 9'h050); load(2, 9'h0CA);
      sif.end_addr = 5'd2; sif.run = 1'b1;
      cyc();
      check("run_state_e", sif.state, 2'b01);
      check("run_en_e", sif.proc_enable, 0);
      cyc();
      check("run_en_e1", sif.proc_enable, 1);
      check("run_tick_e1", sif.tick, T1);
      n = 0;
      while (sif.state !== 2'b11 && n < 40) begin cyc(); n++; end
      check("run_cycles", n, 12);
      check("run_halt_state", sif.state, 2'b11);
      check("run_halt_en", sif.proc_enable, 0);
      check("run_retired", sif.retired, 3);
      check("run_pc", sif.pc, 3);

      // run is ignored in HALT; restart returns to IDLE at pc 0
      repeat (3) cyc();
      check("halt_hold", sif.state, 2'b11);
      sif.run = 1'b0; sif.restart = 1'b1;
      cyc();
      sif.restart = 1'b0;
      check("restart_pc", sif.pc, 0);
      check("restart_din", sif.din, 9'h008);

      // Single step with step held high 10 cycles
      sif.step = 1'b1;
      en_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (sif.proc_enable === 1'b1) en_cnt++;
      end
      sif.step = 1'b0;
      cyc();
      check("step_en_cycles", en_cnt, 4);
      check("step_pc", sif.pc, 1);
      check("step_retired", sif.retired, 4);
      check("step_state", sif.state, 2'b00);

      // Pause: drop run during T2 of the instruction at pc=1
      sif.end_addr = 5'd31; sif.run = 1'b1;
      n = 0;
      while (!(sif.tick == T2 && sif.proc_enable === 1'b1 && sif.pc == 1) && n < 40) begin cyc(); n++; end
      check("pause_reach_t2", sif.tick, T2);
      sif.run = 1'b0;
      wait_state(2'b00, 20, "pause_idle");
      check("pause_pc", sif.pc, 2);
      sif.run = 1'b1;
      cyc();
      check("resume_pc", sif.pc, 2);

      // Load gating: write during RUN is ignored
      cyc();
      load(0, 9'h1FF);
      sif.end_addr = 5'd4;
      wait_state(2'b11, 40, "gate_halt");
      sif.run = 1'b0; sif.restart = 1'b1;
      cyc();
      sif.restart = 1'b0;
      check("gate_keep", sif.din, 9'h008);

      // Execute one instruction to HALT, write in HALT, restart shows new word
      sif.end_addr = 5'd0; sif.run = 1'b1;
      wait_state(2'b11, 20, "halt0");
      sif.run = 1'b0;
      load(0, 9'h1AB);
      sif.restart = 1'b1;
      cyc();
      sif.restart = 1'b0;
      check("restart2_state", sif.state, 2'b00);
      check("restart2_pc", sif.pc, 0);
      check("restart2_din", sif.din, 9'h1AB);

      // Wrap: pause at pc 31, then run with end_addr=3 across 31->0
      sif.end_addr = 5'd31; sif.run = 1'b1;
      wait_pc(30, 200, "wrap_reach30");
      sif.run = 1'b0;
      wait_state(2'b00, 20, "wrap_pause");
      check("wrap_pc31", sif.pc, 31);
      sif.end_addr = 5'd3; sif.run = 1'b1;
      wait_pc(0, 20, "wrap_pc0");
      wait_state(2'b11, 40, "wrap_halt");
      check("wrap_end_pc", sif.pc, 4);
      sif.run = 1'b0;

      // Async reset during T3 in RUN
      sif.restart = 1'b1;
      cyc();
      sif.restart = 1'b0; sif.end_addr = 5'd31; sif.run = 1'b1;
      n = 0;
      while (!(sif.tick == T3 && sif.proc_enable === 1'b1) && n < 20) begin cyc(); n++; end
      check("mrst_reach_t3", sif.tick, T3);
      #2 rst = 1'b1;
      #1;
      m_reset();
      sif.tick = T1;
      check("mrst_din", sif.din, 0);
      check("mrst_pc", sif.pc, 0);
      check("mrst_en", sif.proc_enable, 0);
      check("mrst_state", sif.state, 2'b00);
      check("mrst_retired", sif.retired, 0);
      check("mrst_halted", sif.halted, 0);
      sif.run = 1'b0;
      @(negedge clk);
      cyc();
      rst = 1'b0;
      cyc();

      // Random control and load traffic
      for (int i = 0; i < 800; i++) begin
         sif.run       = ($urandom_range(0, 9) < 3);
         sif.step      = ($urandom_range(0, 3) == 0);
         sif.restart   = ($urandom_range(0, 15) == 0);
         sif.load_we   = ($urandom_range(0, 3) == 0);
         sif.load_addr = 5'($urandom_range(0, DEPTH - 1));
         sif.load_data = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 31) == 0) sif.end_addr = 5'($urandom_range(0, DEPTH - 1));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
